// File: rtl/fp_iterative_divider_if.sv
// Start/done request interface for the iterative floating-point divider.
//   start           : request, sampled by the divider only while idle
//   a, b            : dividend / divisor, captured on an accepted start
//   rnd_mode        : 000 RNE, 001 RTZ, 010 toward -inf, 011 toward +inf, other RNE
//   busy            : divider is working on an operation
//   done            : one-cycle pulse, quotient and exception_flags valid
//   quotient        : result, held until the next accepted start
//   exception_flags : {invalid, div_by_zero, overflow, underflow}
interface fp_iterative_divider_if #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23
);
    localparam int unsigned WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       rnd_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [3:0]       exception_flags;

    modport master (
        output start, a, b, rnd_mode,
        input  busy, done, quotient, exception_flags
    );

    modport slave (
        input  start, a, b, rnd_mode,
        output busy, done, quotient, exception_flags
    );
endinterface

// File: rtl/fp_iterative_divider.sv
// Multi-cycle IEEE-754 divider (quotient = a / b), radix-2 restoring, one
// quotient bit per cycle. Denormals are flushed to zero on input and tiny
// results flush to signed zero.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of fp_iterative_divider_if (start/a/b/rnd_mode in,
//         busy/done/quotient/exception_flags out, all outputs registered)
module fp_iterative_divider #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_iterative_divider_if.slave bus
);
    localparam int unsigned WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int unsigned QBITS = MANT_WIDTH + 3;
    localparam int unsigned SIG_W = MANT_WIDTH + 1;
    localparam int unsigned SUM_W = SIG_W + 1;
    localparam int unsigned REM_W = MANT_WIDTH + 2;
    localparam int unsigned DIF_W = REM_W - 1;
    localparam int unsigned CNT_W = $clog2(QBITS + 1);
    localparam int unsigned E_W   = EXP_WIDTH + 2;

    localparam logic [EXP_WIDTH-1:0]  EXP_ONES = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0]  EXP_MAXF = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [MANT_WIDTH-1:0] MANT_ZERO = '0;
    localparam logic [MANT_WIDTH-1:0] MANT_ONES = {MANT_WIDTH{1'b1}};
    localparam logic signed [E_W-1:0] BIAS  = E_W'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
    localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_WIDTH) - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(QBITS - 1);
    localparam logic [WIDTH-1:0]      QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Captured request and datapath state
    logic [WIDTH-1:0]         a_r;
    logic [WIDTH-1:0]         b_r;
    logic [2:0]               mode_r;
    logic                     sign_r;
    logic signed [E_W-1:0]    exp_r;
    logic [SIG_W-1:0]         mb_r;
    logic [REM_W-1:0]         rem_r;
    logic [QBITS-1:0]         q_r;
    logic [CNT_W-1:0]         cnt_r;

    // Registered outputs
    logic                     busy_q;
    logic                     done_q;
    logic [WIDTH-1:0]         quot_q;
    logic [3:0]               flags_q;

    // FSM strobes
    logic accept_c;
    logic unpack_c;
    logic step_c;
    logic load_c;

    // Unpack
    logic [EXP_WIDTH-1:0]     ea_c;
    logic [EXP_WIDTH-1:0]     eb_c;
    logic [MANT_WIDTH-1:0]    fa_c;
    logic [MANT_WIDTH-1:0]    fb_c;
    logic                     a_zero_c;
    logic                     b_zero_c;
    logic                     a_inf_c;
    logic                     b_inf_c;
    logic                     a_nan_c;
    logic                     b_nan_c;
    logic                     sign_c;
    logic signed [E_W-1:0]    exp_c;
    logic                     special_c;
    logic [WIDTH-1:0]         spec_q_c;
    logic [3:0]               spec_f_c;

    // Division step
    logic                     ge_c;
    logic [DIF_W-1:0]         diff_c;
    logic [REM_W-1:0]         rem_step_c;

    // Round / range
    logic                     norm_c;
    logic [SIG_W-1:0]         mant_pre_c;
    logic                     guard_c;
    logic                     rbit_c;
    logic                     sticky_c;
    logic                     inexact_c;
    logic                     inc_c;
    logic [SUM_W-1:0]         sum_c;
    logic [MANT_WIDTH-1:0]    frac_c;
    logic signed [E_W-1:0]    exp_n_c;
    logic signed [E_W-1:0]    exp_fin_c;
    logic                     to_inf_c;
    logic [WIDTH-1:0]         rnd_q_c;
    logic [3:0]               rnd_f_c;

    logic [WIDTH-1:0]         result_c;
    logic [3:0]               flags_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        unpack_c   = 1'b0;
        step_c     = 1'b0;
        load_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept_c   = 1'b1;
                    state_next = S_UNPACK;
                end
            end
            S_UNPACK: begin
                unpack_c = 1'b1;
                if (special_c) begin
                    load_c     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_DIV;
                end
            end
            S_DIV: begin
                step_c = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                load_c     = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand field decode
    assign ea_c     = a_r[WIDTH-2 -: EXP_WIDTH];
    assign eb_c     = b_r[WIDTH-2 -: EXP_WIDTH];
    assign fa_c     = a_r[MANT_WIDTH-1:0];
    assign fb_c     = b_r[MANT_WIDTH-1:0];
    assign a_zero_c = (ea_c == '0);
    assign b_zero_c = (eb_c == '0);
    assign a_inf_c  = (ea_c == EXP_ONES) && (fa_c == '0);
    assign b_inf_c  = (eb_c == EXP_ONES) && (fb_c == '0);
    assign a_nan_c  = (ea_c == EXP_ONES) && (fa_c != '0);
    assign b_nan_c  = (eb_c == EXP_ONES) && (fb_c != '0);
    assign sign_c   = a_r[WIDTH-1] ^ b_r[WIDTH-1];
    assign exp_c    = $signed(E_W'(ea_c)) - $signed(E_W'(eb_c)) + BIAS;

    // Special operands, first match wins
    always_comb begin
        special_c = 1'b1;
        spec_q_c  = '0;
        spec_f_c  = 4'b0000;
        if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c)) begin
            spec_q_c = QNAN;
            spec_f_c = 4'b1000;
        end else if (b_zero_c && !a_inf_c) begin
            spec_q_c = {sign_c, EXP_ONES, MANT_ZERO};
            spec_f_c = 4'b0100;
        end else if (a_inf_c) begin
            spec_q_c = {sign_c, EXP_ONES, MANT_ZERO};
            spec_f_c = 4'b0010;
        end else if (a_zero_c || b_inf_c) begin
            spec_q_c = {sign_c, {(WIDTH-1){1'b0}}};
            spec_f_c = 4'b0001;
        end else begin
            special_c = 1'b0;
        end
    end

    // Restoring step: remainder stays below 2*divisor, so the shifted
    // difference always fits without its top bit.
    assign ge_c       = (rem_r >= REM_W'(mb_r));
    assign diff_c     = DIF_W'(rem_r - REM_W'(mb_r));
    assign rem_step_c = ge_c ? {diff_c, 1'b0} : {rem_r[REM_W-2:0], 1'b0};

    // Normalize, round and range-check the finished quotient
    always_comb begin
        norm_c     = q_r[QBITS-1];
        mant_pre_c = norm_c ? q_r[QBITS-1 -: SIG_W] : q_r[QBITS-2 -: SIG_W];
        guard_c    = norm_c ? q_r[1] : q_r[0];
        rbit_c     = norm_c & q_r[0];
        sticky_c   = |rem_r;
        inexact_c  = guard_c | rbit_c | sticky_c;
        exp_n_c    = norm_c ? exp_r : (exp_r - E_ONE);
        inc_c      = 1'b0;
        case (mode_r)
            3'b001:  inc_c = 1'b0;
            3'b010:  inc_c = sign_r & inexact_c;
            3'b011:  inc_c = ~sign_r & inexact_c;
            default: inc_c = guard_c & (rbit_c | sticky_c | mant_pre_c[0]);
        endcase
        sum_c = {1'b0, mant_pre_c} + SUM_W'(inc_c);
        // Carry-out only happens from all-ones, leaving 1.000..0 after the shift
        if (sum_c[SIG_W]) begin
            frac_c    = sum_c[SIG_W-1:1];
            exp_fin_c = exp_n_c + E_ONE;
        end else begin
            frac_c    = sum_c[MANT_WIDTH-1:0];
            exp_fin_c = exp_n_c;
        end
        case (mode_r)
            3'b001:  to_inf_c = 1'b0;
            3'b010:  to_inf_c = sign_r;
            3'b011:  to_inf_c = ~sign_r;
            default: to_inf_c = 1'b1;
        endcase
        if (exp_fin_c >= E_MAX) begin
            rnd_q_c = to_inf_c ? {sign_r, EXP_ONES, MANT_ZERO}
                               : {sign_r, EXP_MAXF, MANT_ONES};
            rnd_f_c = 4'b0010;
        end else if (exp_fin_c < E_ONE) begin
            rnd_q_c = {sign_r, {(WIDTH-1){1'b0}}};
            rnd_f_c = 4'b0001;
        end else begin
            rnd_q_c = {sign_r, exp_fin_c[EXP_WIDTH-1:0], frac_c};
            rnd_f_c = 4'b0000;
        end
    end

    // Special results are loaded straight from UNPACK, the rest from ROUND
    assign result_c = (state == S_UNPACK) ? spec_q_c : rnd_q_c;
    assign flags_c  = (state == S_UNPACK) ? spec_f_c : rnd_f_c;

    // Request capture and division datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            mb_r   <= '0;
            rem_r  <= '0;
            q_r    <= '0;
            cnt_r  <= '0;
        end else begin
            if (accept_c) begin
                a_r    <= bus.a;
                b_r    <= bus.b;
                mode_r <= bus.rnd_mode;
            end
            if (unpack_c) begin
                sign_r <= sign_c;
                exp_r  <= exp_c;
                mb_r   <= {1'b1, fb_c};
                rem_r  <= REM_W'({1'b1, fa_c});
                q_r    <= '0;
                cnt_r  <= '0;
            end
            if (step_c) begin
                rem_r <= rem_step_c;
                q_r   <= {q_r[QBITS-2:0], ge_c};
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Output registers; busy/done follow the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            flags_q <= '0;
        end else begin
            busy_q <= (state_next != S_IDLE);
            done_q <= (state_next == S_DONE);
            if (load_c) begin
                quot_q  <= result_c;
                flags_q <= flags_c;
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.quotient        = quot_q;
    assign bus.exception_flags = flags_q;

endmodule

// File: tb/tb_fp_iterative_divider.sv
// Self-checking bench for fp_iterative_divider: directed vector table,
// randomized operands against an integer-division reference model, and
// handshake / mid-operation reset sequences.
module tb_fp_iterative_divider;
    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned MANT_WIDTH = 23;
    localparam int          LAT_NORMAL = 29;
    localparam int          LAT_SPEC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_iterative_divider_if #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) bus ();

    fp_iterative_divider #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then rounding
    // decided by comparing the discarded part against one half ulp.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] m, output logic [31:0] q,
                                    output logic [3:0] f, output bit sp);
        int ea, eb, e, drop;
        longint unsigned ma, mb, num, qi, rem, keep, rest, half;
        bit sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        bit above, tie, inexact, up, to_inf;
        logic [2:0] md;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sgn = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 23'h0);
        b_inf  = (eb == 255) && (b[22:0] == 23'h0);
        a_nan  = (ea == 255) && (a[22:0] != 23'h0);
        b_nan  = (eb == 255) && (b[22:0] != 23'h0);
        md = (m > 3'd3) ? 3'd0 : m;
        sp = 1'b1;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            q = 32'h7FC00000; f = 4'b1000; return;
        end
        if (b_zero && !a_inf) begin
            q = {sgn, 8'hFF, 23'h0}; f = 4'b0100; return;
        end
        if (a_inf) begin
            q = {sgn, 8'hFF, 23'h0}; f = 4'b0010; return;
        end
        if (a_zero || b_inf) begin
            q = {sgn, 31'h0}; f = 4'b0001; return;
        end
        sp = 1'b0;
        ma = 64'h800000 | 64'(a[22:0]);
        mb = 64'h800000 | 64'(b[22:0]);
        num = ma << 38;
        qi  = num / mb;
        rem = num % mb;
        e = ea - eb + 127;
        if (qi >= (64'd1 << 38)) begin
            drop = 15;
        end else begin
            drop = 14;
            e = e - 1;
        end
        keep = qi >> drop;
        rest = qi & ((64'd1 << drop) - 64'd1);
        half = 64'd1 << (drop - 1);
        above   = (rest > half) || ((rest == half) && (rem != 0));
        tie     = (rest == half) && (rem == 0);
        inexact = (rest != 0) || (rem != 0);
        case (md)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && inexact;
            3'd3:    up = !sgn && inexact;
            default: up = above || (tie && keep[0]);
        endcase
        keep = keep + 64'(up);
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (md == 3'd0) || (md == 3'd2 && sgn) || (md == 3'd3 && !sgn);
            q = to_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
            f = 4'b0010;
        end else if (e <= 0) begin
            q = {sgn, 31'h0};
            f = 4'b0001;
        end else begin
            q = {sgn, 8'(e), keep[22:0]};
            f = 4'b0000;
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int sel;
        v = $urandom;
        sel = $urandom_range(0, 19);
        if (sel == 0)      v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel == 2) begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
        else if (sel < 7)  v[30:23] = 8'($urandom_range(1, 254));
        else if (sel == 7) begin v[30:23] = 8'($urandom_range(100, 154)); v[22:0] = 23'h7FFFFF; end
        else               v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    // Issue one request from an idle, post-edge point; idx counts cycles after
    // the accepting edge (1 = first busy cycle).
    task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic [2:0] m,
                         output logic [31:0] q, output logic [3:0] f,
                         output int lat, output bit hs_ok);
        int idx;
        bus.a = a_i;
        bus.b = b_i;
        bus.rnd_mode = m;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 1;
        hs_ok = 1'b1;
        while (!bus.done && idx < 100) begin
            if (!bus.busy) hs_ok = 1'b0;
            @(posedge clk); #1;
            idx++;
        end
        if (!bus.busy) hs_ok = 1'b0;
        lat = bus.done ? idx : -1;
        q = bus.quotient;
        f = bus.exception_flags;
        @(posedge clk); #1;
        if (bus.busy || bus.done || bus.quotient !== q) hs_ok = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q, eq, ra, rb;
        logic [3:0]  f, ef;
        logic [2:0]  rm;
        int          lat, idx, done_cnt;
        bit          hs, sp;

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.rnd_mode = '0;

        vecs.push_back('{32'h40400000, 32'h40000000, 3'b000, 32'h3FC00000, 4'b0000, LAT_NORMAL});
        vecs.push_back('{32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 4'b0000, LAT_NORMAL});
        vecs.push_back('{32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 4'b0000, LAT_NORMAL});
        vecs.push_back('{32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 4'b0000, LAT_NORMAL});
        vecs.push_back('{32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 4'b0000, LAT_NORMAL});
        vecs.push_back('{32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 4'b0000, LAT_NORMAL});
        vecs.push_back('{32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 4'b0100, LAT_SPEC});
        vecs.push_back('{32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 4'b1000, LAT_SPEC});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 4'b1000, LAT_SPEC});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 4'b1000, LAT_SPEC});
        vecs.push_back('{32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 4'b0010, LAT_SPEC});
        vecs.push_back('{32'h40000000, 32'hFF800000, 3'b000, 32'h80000000, 4'b0001, LAT_SPEC});
        vecs.push_back('{32'h80000000, 32'h40A00000, 3'b000, 32'h80000000, 4'b0001, LAT_SPEC});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 3'b000, 32'h7F800000, 4'b0010, LAT_NORMAL});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 3'b001, 32'h7F7FFFFF, 4'b0010, LAT_NORMAL});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 3'b010, 32'h7F7FFFFF, 4'b0010, LAT_NORMAL});
        vecs.push_back('{32'hFF7FFFFF, 32'h3F000000, 3'b010, 32'hFF800000, 4'b0010, LAT_NORMAL});
        vecs.push_back('{32'hFF7FFFFF, 32'h3F000000, 3'b011, 32'hFF7FFFFF, 4'b0010, LAT_NORMAL});
        vecs.push_back('{32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 4'b0001, LAT_NORMAL});
        vecs.push_back('{32'hC0C00000, 32'h40000000, 3'b000, 32'hC0400000, 4'b0000, LAT_NORMAL});

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quotient", bus.quotient, 32'h0);
        check("reset flags", 32'(bus.exception_flags), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].mode, q, f, lat, hs);
            check($sformatf("vec%0d quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].f));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d busy/done shape", i), 32'(hs), 32'd1);
        end

        // Random operands against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            rm = 3'($urandom_range(0, 7));
            ref_div(ra, rb, rm, eq, ef, sp);
            do_op(ra, rb, rm, q, f, lat, hs);
            check($sformatf("rand%0d %h/%h m%0d quotient", i, ra, rb, rm), q, eq);
            check($sformatf("rand%0d %h/%h m%0d flags", i, ra, rb, rm), 32'(f), 32'(ef));
            check($sformatf("rand%0d latency", i), 32'(lat), sp ? 32'(LAT_SPEC) : 32'(LAT_NORMAL));
            check($sformatf("rand%0d busy/done shape", i), 32'(hs), 32'd1);
        end

        // start pulsed mid-division must be ignored
        bus.a = 32'h40400000;
        bus.b = 32'h40000000;
        bus.rnd_mode = 3'b000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 1;
        while (!bus.done && idx < 100) begin
            if (idx == 5) begin
                bus.a = 32'h3F800000;
                bus.b = 32'h40400000;
                bus.rnd_mode = 3'b001;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            idx++;
        end
        bus.start = 1'b0;
        check("busy-start latency", 32'(bus.done ? idx : -1), 32'(LAT_NORMAL));
        check("busy-start quotient", bus.quotient, 32'h3FC00000);
        @(posedge clk); #1;
        check("busy-start no restart", 32'(bus.busy), 32'd0);

        // Reset at DIV cycle 10 abandons the operation
        bus.a = 32'h3F800000;
        bus.b = 32'h40400000;
        bus.rnd_mode = 3'b000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k < 11; k++) begin
            @(posedge clk); #1;
        end
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #2;
        check("mid-reset busy", 32'(bus.busy), 32'd0);
        check("mid-reset done", 32'(bus.done), 32'd0);
        check("mid-reset quotient", bus.quotient, 32'h0);
        check("mid-reset flags", 32'(bus.exception_flags), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        check("post-reset idle", 32'(done_cnt), 32'd0);
        do_op(32'h40400000, 32'h40000000, 3'b000, q, f, lat, hs);
        check("post-reset quotient", q, 32'h3FC00000);
        check("post-reset flags", 32'(f), 32'h0);
        check("post-reset latency", 32'(lat), 32'(LAT_NORMAL));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
